// File: rtl/time_unit_counter.sv
// Single time-unit counter (ms/sec/min/hr) with binary value, incremental BCD digits and
// same-cycle carry/borrow. Optional i_up prescaler is enabled by defining TIME_UNIT_PRESCALE_EN.
module time_unit_counter #(
   parameter int P_MOD   = 60,
   parameter int P_WIDTH = 7,
   parameter int P_DIV   = 10
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_clear,
   input  logic               i_up,
   input  logic               i_down,
   output logic               o_carryup,
   output logic               o_borrow,
   output logic [P_WIDTH-1:0] o_value,
   output logic [3:0]         o_tens,
   output logic [3:0]         o_ones
);

   localparam logic [P_WIDTH-1:0] C_MAX      = P_WIDTH'(P_MOD - 1);
   localparam logic [3:0]         C_MAX_TENS = 4'((P_MOD - 1) / 10);
   localparam logic [3:0]         C_MAX_ONES = 4'((P_MOD - 1) % 10);

   if (P_MOD < 2 || P_MOD > 100 || (2 ** P_WIDTH) < P_MOD || P_DIV < 1 || P_DIV > 1024) begin : g_bad_param
      $error("time_unit_counter: illegal P_MOD/P_WIDTH/P_DIV combination");
   end

   logic [P_WIDTH-1:0] r_value;
   logic [3:0]         r_tens;
   logic [3:0]         r_ones;
   logic               w_tick;
   logic               w_inc;
   logic               w_dec;
   logic               w_at_max;
   logic               w_at_zero;

`ifdef TIME_UNIT_PRESCALE_EN
   localparam int                C_PS_W    = (P_DIV > 1) ? $clog2(P_DIV) : 1;
   localparam logic [C_PS_W-1:0] C_PS_LAST = C_PS_W'(P_DIV - 1);

   logic [C_PS_W-1:0] r_prescale;

   assign w_tick = (r_prescale == C_PS_LAST);

   // Counts only cycles that request a lone increment; a hold pair restarts the divide.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_prescale <= '0;
      end else if (i_clear || (i_up && i_down)) begin
         r_prescale <= '0;
      end else if (i_up) begin
         r_prescale <= w_tick ? '0 : r_prescale + C_PS_W'(1);
      end
   end
`else
   assign w_tick = 1'b1;
`endif

   assign w_at_max  = (r_value == C_MAX);
   assign w_at_zero = (r_value == '0);
   assign w_inc     = ~i_clear & i_up & ~i_down & w_tick;
   assign w_dec     = ~i_clear & i_down & ~i_up;

   // NOTE: reset gates the combinational carries so a chain collapses instantly, not at the next edge.
   assign o_carryup = i_rstn & w_inc & w_at_max;
   assign o_borrow  = i_rstn & w_dec & w_at_zero;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_value <= '0;
         r_tens  <= '0;
         r_ones  <= '0;
      end else if (i_clear) begin
         r_value <= '0;
         r_tens  <= '0;
         r_ones  <= '0;
      end else if (w_inc) begin
         if (w_at_max) begin
            r_value <= '0;
            r_tens  <= '0;
            r_ones  <= '0;
         end else begin
            r_value <= r_value + P_WIDTH'(1);
            if (r_ones == 4'd9) begin
               r_ones <= 4'd0;
               r_tens <= r_tens + 4'd1;
            end else begin
               r_ones <= r_ones + 4'd1;
            end
         end
      end else if (w_dec) begin
         if (w_at_zero) begin
            r_value <= C_MAX;
            r_tens  <= C_MAX_TENS;
            r_ones  <= C_MAX_ONES;
         end else begin
            r_value <= r_value - P_WIDTH'(1);
            if (r_ones == 4'd0) begin
               r_ones <= 4'd9;
               r_tens <= r_tens - 4'd1;
            end else begin
               r_ones <= r_ones - 4'd1;
            end
         end
      end
   end

   assign o_value = r_value;
   assign o_tens  = r_tens;
   assign o_ones  = r_ones;

endmodule

// File: tb/tb_time_unit_counter.sv
// Scoreboard bench for time_unit_counter: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against four independent instances.
module tb_time_unit_counter;

   typedef enum int {U60, U24, CH, PS} unit_e;

   typedef struct {
      unit_e unit;
      string tag;
      int    cu;   // chain: lower o_carryup
      int    bo;   // chain: upper o_carryup
      int    val;
      int    tens;
      int    ones;
   } exp_t;

   logic clk = 1'b0;
   logic rstn;

   logic       u60_clr, u60_up, u60_down, u60_cu, u60_bo;
   logic [6:0] u60_val;
   logic [3:0] u60_tens, u60_ones;

   logic       u24_clr, u24_up, u24_down, u24_cu, u24_bo;
   logic [4:0] u24_val;
   logic [3:0] u24_tens, u24_ones;

   logic       ch_up, lo_cu, lo_bo, hi_cu, hi_bo;
   logic [3:0] lo_val, lo_tens, lo_ones;
   logic [6:0] hi_val;
   logic [3:0] hi_tens, hi_ones;

   logic       ps_up, ps_cu, ps_bo;
   logic [6:0] ps_val;
   logic [3:0] ps_tens, ps_ones;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   time_unit_counter #(.P_MOD(60), .P_WIDTH(7), .P_DIV(1)) u_60 (
      .i_clk(clk), .i_rstn(rstn), .i_clear(u60_clr), .i_up(u60_up), .i_down(u60_down),
      .o_carryup(u60_cu), .o_borrow(u60_bo), .o_value(u60_val), .o_tens(u60_tens), .o_ones(u60_ones));

   time_unit_counter #(.P_MOD(24), .P_WIDTH(5), .P_DIV(1)) u_24 (
      .i_clk(clk), .i_rstn(rstn), .i_clear(u24_clr), .i_up(u24_up), .i_down(u24_down),
      .o_carryup(u24_cu), .o_borrow(u24_bo), .o_value(u24_val), .o_tens(u24_tens), .o_ones(u24_ones));

   time_unit_counter #(.P_MOD(10), .P_WIDTH(4), .P_DIV(1)) u_lo (
      .i_clk(clk), .i_rstn(rstn), .i_clear(1'b0), .i_up(ch_up), .i_down(1'b0),
      .o_carryup(lo_cu), .o_borrow(lo_bo), .o_value(lo_val), .o_tens(lo_tens), .o_ones(lo_ones));

   time_unit_counter #(.P_MOD(60), .P_WIDTH(7), .P_DIV(1)) u_hi (
      .i_clk(clk), .i_rstn(rstn), .i_clear(1'b0), .i_up(lo_cu), .i_down(lo_bo),
      .o_carryup(hi_cu), .o_borrow(hi_bo), .o_value(hi_val), .o_tens(hi_tens), .o_ones(hi_ones));

   time_unit_counter #(.P_MOD(60), .P_WIDTH(7), .P_DIV(10)) u_ps (
      .i_clk(clk), .i_rstn(rstn), .i_clear(1'b0), .i_up(ps_up), .i_down(1'b0),
      .o_carryup(ps_cu), .o_borrow(ps_bo), .o_value(ps_val), .o_tens(ps_tens), .o_ones(ps_ones));

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input unit_e unit, input string tag, input int cu, input int bo,
                       input int val, input int tens, input int ones);
      exp_t e;
      e.unit = unit; e.tag = tag; e.cu = cu; e.bo = bo;
      e.val = val; e.tens = tens; e.ones = ones;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: outputs are stable mid-cycle, so every queued expectation is compared at negedge.
   initial begin
      forever begin
         @(negedge clk);
         while (sb.size() > 0) begin
            exp_t e;
            int a_cu, a_bo, a_val, a_tens, a_ones;
            e = sb.pop_front();
            case (e.unit)
               U60: begin a_cu = int'(u60_cu); a_bo = int'(u60_bo); a_val = int'(u60_val); a_tens = int'(u60_tens); a_ones = int'(u60_ones); end
               U24: begin a_cu = int'(u24_cu); a_bo = int'(u24_bo); a_val = int'(u24_val); a_tens = int'(u24_tens); a_ones = int'(u24_ones); end
               CH:  begin a_cu = int'(lo_cu);  a_bo = int'(hi_cu);  a_val = int'(hi_val);  a_tens = int'(hi_tens);  a_ones = int'(hi_ones);  end
               default: begin a_cu = int'(ps_cu); a_bo = int'(ps_bo); a_val = int'(ps_val); a_tens = int'(ps_tens); a_ones = int'(ps_ones); end
            endcase
            check({e.tag, ".carry"}, a_cu, e.cu);
            check({e.tag, ".borrow"}, a_bo, e.bo);
            check({e.tag, ".value"}, a_val, e.val);
            check({e.tag, ".tens"}, a_tens, e.tens);
            check({e.tag, ".ones"}, a_ones, e.ones);
         end
      end
   end

   initial begin
      rstn = 1'b0;
      u60_clr = 0; u60_up = 0; u60_down = 0;
      u24_clr = 0; u24_up = 0; u24_down = 0;
      ch_up = 0; ps_up = 0;
      repeat (2) step();
      rstn = 1'b1;
      push(U60, "reset60", 0, 0, 0, 0, 0);
      push(U24, "reset24", 0, 0, 0, 0, 0);
      push(CH,  "reset_ch", 0, 0, 0, 0, 0);
      push(PS,  "reset_ps", 0, 0, 0, 0, 0);

      // Full modulus-60 sweep
      for (int i = 0; i < 60; i++) begin
         step(); u60_up = 1;
         push(U60, $sformatf("count60[%0d]", i), (i == 59) ? 1 : 0, 0, i, i / 10, i % 10);
      end
      step(); u60_up = 0;
      push(U60, "wrap60", 0, 0, 0, 0, 0);

      // Borrow to 59, hold pair, clear priority
      step(); u60_down = 1;
      push(U60, "borrow60", 0, 1, 0, 0, 0);
      step(); u60_up = 1;
      push(U60, "hold_both_a", 0, 0, 59, 5, 9);
      step();
      push(U60, "hold_both_b", 0, 0, 59, 5, 9);
      step(); u60_down = 0; u60_clr = 1;
      push(U60, "clear_at_59", 0, 0, 59, 5, 9);
      step(); u60_clr = 0;
      push(U60, "after_clear", 0, 0, 0, 0, 0);
      step();
      push(U60, "recount1", 0, 0, 1, 0, 1);
      step();
      push(U60, "recount2", 0, 0, 2, 0, 2);

      // Async reset mid-count with i_up held, then borrow gated while in reset
      step(); rstn = 1'b0;
      push(U60, "async_rst", 0, 0, 0, 0, 0);
      step(); u60_up = 0; u60_down = 1;
      push(U60, "rst_gate", 0, 0, 0, 0, 0);
      step(); rstn = 1'b1; u60_down = 0;
      push(U60, "rst_release", 0, 0, 0, 0, 0);

      // Modulus-24 borrow, carry, and mid-range decrement across a tens boundary
      step(); u24_down = 1;
      push(U24, "borrow24", 0, 1, 0, 0, 0);
      step(); u24_down = 0; u24_up = 1;
      push(U24, "carry24", 1, 0, 23, 2, 3);
      for (int i = 0; i < 10; i++) begin
         step(); u24_up = 1;
         push(U24, $sformatf("up24[%0d]", i), 0, 0, i, i / 10, i % 10);
      end
      step(); u24_up = 0; u24_down = 1;
      push(U24, "dec24_10", 0, 0, 10, 1, 0);
      step();
      push(U24, "dec24_9", 0, 0, 9, 0, 9);
      step(); u24_down = 0;
      push(U24, "dec24_8", 0, 0, 8, 0, 8);

      // Two-stage chain, 600 lower increments
      for (int i = 0; i < 600; i++) begin
         step(); ch_up = 1;
         push(CH, $sformatf("chain[%0d]", i), (i % 10 == 9) ? 1 : 0, (i == 599) ? 1 : 0,
              (i / 10) % 60, ((i / 10) % 60) / 10, (i / 10) % 10);
      end
      step(); ch_up = 0;
      push(CH, "chain_end", 0, 0, 0, 0, 0);

`ifdef TIME_UNIT_PRESCALE_EN
      for (int i = 0; i < 100; i++) begin
         step(); ps_up = 1;
         push(PS, $sformatf("ps_run[%0d]", i), 0, 0, i / 10, (i / 10) / 10, (i / 10) % 10);
      end
      step(); ps_up = 0;
      push(PS, "ps_after100", 0, 0, 10, 1, 0);
      for (int i = 0; i < 5; i++) begin
         step(); ps_up = 1;
         push(PS, $sformatf("ps_part_a[%0d]", i), 0, 0, 10, 1, 0);
      end
      for (int i = 0; i < 3; i++) begin
         step(); ps_up = 0;
         push(PS, $sformatf("ps_gap[%0d]", i), 0, 0, 10, 1, 0);
      end
      for (int i = 0; i < 5; i++) begin
         step(); ps_up = 1;
         push(PS, $sformatf("ps_part_b[%0d]", i), 0, 0, 10, 1, 0);
      end
      step(); ps_up = 0;
      push(PS, "ps_resumed", 0, 0, 11, 1, 1);
`endif

      step();
      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
      check("scoreboard_drain", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
